// File: rtl/logistic_iter_ctrl.sv
// Logistic-map sweep scheduler: x' = r*x*(1-x) per oscillator slot on one shared external
// multiplier, one sweep per epoch, r stepped after each completed sweep.
module logistic_iter_ctrl #(
   parameter int unsigned N_OSC    = 8,
   parameter int unsigned ITER_LEN = 15361,
   parameter int unsigned FRAC     = 16,
   parameter int unsigned R_INC    = 2,
   parameter int unsigned R_INIT   = 3 << FRAC,
   parameter int unsigned R_MAX    = (4 << FRAC) - 1,
   localparam int unsigned IDXW    = (N_OSC > 1) ? $clog2(N_OSC) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   output logic                mul_req,
   output logic [FRAC+1:0]     mul_a,
   output logic [FRAC+1:0]     mul_b,
   input  logic                mul_ack,
   input  logic                mul_done,
   input  logic [2*FRAC+3:0]   mul_p,
   output logic                x_valid,
   output logic [IDXW-1:0]     x_idx,
   output logic [FRAC-1:0]     x_val,
   output logic [FRAC+1:0]     r_val,
   output logic                busy,
   output logic                overrun
);
   localparam int unsigned AW  = FRAC + 2;
   localparam int unsigned RW  = FRAC + 3;
   localparam int unsigned PW  = 2 * FRAC + 4;
   localparam int unsigned CW  = (ITER_LEN > 1) ? $clog2(ITER_LEN) : 1;
   localparam logic [AW-1:0] ONE = AW'(1 << FRAC);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ1, S_WAIT1, S_REQ2, S_WAIT2, S_WRITE
   } state_t;

   state_t              state, state_d;
   logic [CW-1:0]       cnt;
   logic                tick;
   logic [IDXW-1:0]     slot, slot_d;
   logic [AW-1:0]       r, r_d, t, t_d;
   logic [FRAC-1:0]     x [N_OSC];
   logic                last_c, wr_x_c;
   logic [FRAC-1:0]     y_c, x_cur_c;
   logic                mul_req_d, x_valid_d, overrun_d;
   logic [AW-1:0]       mul_a_d, mul_b_d;
   logic [IDXW-1:0]     x_idx_d;
   logic [FRAC-1:0]     x_val_d;
   logic                unused_c;

   assign unused_c = ^{mul_p[FRAC-1:0], mul_p[PW-1:FRAC+AW]};
   assign r_val    = r;

   // Epoch counter; tick is a registered one-cycle pulse on wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (en) begin
            if (cnt == CW'(ITER_LEN - 1)) begin
               cnt  <= '0;
               tick <= 1'b1;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         S_IDLE:  if (tick)     state_d = S_REQ1;
         S_REQ1:  if (mul_ack)  state_d = S_WAIT1;
         S_WAIT1: if (mul_done) state_d = S_REQ2;
         S_REQ2:  if (mul_ack)  state_d = S_WAIT2;
         S_WAIT2: if (mul_done) state_d = S_WRITE;
         S_WRITE: state_d = last_c ? S_IDLE : S_REQ1;
         default: state_d = S_IDLE;
      endcase
   end

   // Next values of the datapath and of every registered output
   always_comb begin
      slot_d    = slot;
      r_d       = r;
      t_d       = t;
      wr_x_c    = 1'b0;
      mul_a_d   = mul_a;
      mul_b_d   = mul_b;
      x_valid_d = 1'b0;
      x_idx_d   = x_idx;
      x_val_d   = x_val;
      overrun_d = overrun | (tick && (state != S_IDLE));
      last_c    = (slot == IDXW'(N_OSC - 1));
      y_c       = mul_p[FRAC +: FRAC];
      if (y_c == '0) y_c = FRAC'(1);
      case (state)
         S_IDLE:  if (tick) slot_d = '0;
         S_WAIT1: if (mul_done) t_d = AW'(mul_p >> FRAC);
         S_WAIT2: begin
            if (mul_done) begin
               wr_x_c    = 1'b1;
               x_valid_d = 1'b1;
               x_idx_d   = slot;
               x_val_d   = y_c;
            end
         end
         S_WRITE: begin
            if (!last_c)                                  slot_d = slot + IDXW'(1);
            else if (RW'(r) + RW'(R_INC) > RW'(R_MAX))    r_d    = AW'(R_INIT);
            else                                          r_d    = r + AW'(R_INC);
         end
         default: ;
      endcase
      x_cur_c   = x[slot_d];
      mul_req_d = (state_d == S_REQ1) || (state_d == S_REQ2);
      if (state_d == S_REQ1) begin
         mul_a_d = AW'(x_cur_c);
         mul_b_d = ONE - AW'(x_cur_c);
      end else if (state_d == S_REQ2) begin
         mul_a_d = r;
         mul_b_d = t_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot    <= '0;
         r       <= AW'(R_INIT);
         t       <= '0;
         for (int i = 0; i < N_OSC; i++) x[i] <= FRAC'((i + 1) << (FRAC - 4));
         mul_req <= 1'b0;
         mul_a   <= '0;
         mul_b   <= '0;
         x_valid <= 1'b0;
         x_idx   <= '0;
         x_val   <= '0;
         busy    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         slot    <= slot_d;
         r       <= r_d;
         t       <= t_d;
         if (wr_x_c) x[slot] <= y_c;
         mul_req <= mul_req_d;
         mul_a   <= mul_a_d;
         mul_b   <= mul_b_d;
         x_valid <= x_valid_d;
         x_idx   <= x_idx_d;
         x_val   <= x_val_d;
         busy    <= (state_d != S_IDLE);
         overrun <= overrun_d;
      end
   end
endmodule

// File: tb/tb_logistic_iter_ctrl.sv
// Directed bench: three controller instances (nominal r, r=0 floor, r at wrap edge) each
// driven by a behavioural multiplier with programmable ack and latency.
`timescale 1ns/1ps
module tb_logistic_iter_ctrl;
   localparam int unsigned NI = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [NI-1:0]        rst_n, en, mul_req, mul_ack, mul_done, x_valid, busy, overrun;
   logic [NI-1:0][17:0]  mul_a, mul_b, r_val;
   logic [NI-1:0][35:0]  mul_p;
   logic [NI-1:0][2:0]   x_idx;
   logic [NI-1:0][15:0]  x_val;

   int lat  [NI];
   int mcnt [NI];
   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int t_first, t_last;
   logic [15:0] x_first;

   logic [NI-1:0][7:0][15:0] xm;
   logic [NI-1:0][17:0]      rm;

   logistic_iter_ctrl #(.N_OSC(8), .ITER_LEN(16), .FRAC(16), .R_INC(2),
                        .R_INIT(3 << 16), .R_MAX((4 << 16) - 1)) u_dut (
      .clk(clk), .rst_n(rst_n[0]), .en(en[0]), .mul_req(mul_req[0]), .mul_a(mul_a[0]),
      .mul_b(mul_b[0]), .mul_ack(mul_ack[0]), .mul_done(mul_done[0]), .mul_p(mul_p[0]),
      .x_valid(x_valid[0]), .x_idx(x_idx[0]), .x_val(x_val[0]), .r_val(r_val[0]),
      .busy(busy[0]), .overrun(overrun[0]));

   logistic_iter_ctrl #(.N_OSC(8), .ITER_LEN(16), .FRAC(16), .R_INC(0),
                        .R_INIT(0), .R_MAX((4 << 16) - 1)) u_floor (
      .clk(clk), .rst_n(rst_n[1]), .en(en[1]), .mul_req(mul_req[1]), .mul_a(mul_a[1]),
      .mul_b(mul_b[1]), .mul_ack(mul_ack[1]), .mul_done(mul_done[1]), .mul_p(mul_p[1]),
      .x_valid(x_valid[1]), .x_idx(x_idx[1]), .x_val(x_val[1]), .r_val(r_val[1]),
      .busy(busy[1]), .overrun(overrun[1]));

   logistic_iter_ctrl #(.N_OSC(8), .ITER_LEN(16), .FRAC(16), .R_INC(2),
                        .R_INIT((4 << 16) - 2), .R_MAX((4 << 16) - 1)) u_wrap (
      .clk(clk), .rst_n(rst_n[2]), .en(en[2]), .mul_req(mul_req[2]), .mul_a(mul_a[2]),
      .mul_b(mul_b[2]), .mul_ack(mul_ack[2]), .mul_done(mul_done[2]), .mul_p(mul_p[2]),
      .x_valid(x_valid[2]), .x_idx(x_idx[2]), .x_val(x_val[2]), .r_val(r_val[2]),
      .busy(busy[2]), .overrun(overrun[2]));

   // Behavioural multiplier per instance: product captured on accept, done after lat cycles
   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int k = 0; k < NI; k++) begin
         mul_done[k] <= 1'b0;
         if (mcnt[k] > 0) begin
            mcnt[k] <= mcnt[k] - 1;
            if (mcnt[k] == 1) mul_done[k] <= 1'b1;
         end
         if (mul_req[k] && mul_ack[k]) begin
            mul_p[k] <= 36'(mul_a[k]) * 36'(mul_b[k]);
            if (lat[k] <= 1) mul_done[k] <= 1'b1;
            else             mcnt[k]     <= lat[k] - 1;
         end
      end
   end

   function automatic logic [15:0] step(input logic [15:0] x, input logic [17:0] r);
      logic [35:0] p1, p2;
      logic [17:0] t;
      logic [15:0] y;
      p1 = 36'(x) * 36'(18'h10000 - 18'(x));
      t  = 18'(p1 >> 16);
      p2 = 36'(r) * 36'(t);
      y  = p2[31:16];
      if (y == 16'd0) y = 16'd1;
      return y;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // which: 0 = x_valid, 1 = mul_req, 2 = not busy
   task automatic wait_sig(input int k, input int which, input int budget, input string tag);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(posedge clk); #1;
         case (which)
            0:       seen = x_valid[k];
            1:       seen = mul_req[k];
            default: seen = !busy[k];
         endcase
         if (seen) break;
      end
      chk(tag, 64'(seen), 64'd1);
   endtask

   task automatic reset_model(input int k, input logic [17:0] r);
      for (int i = 0; i < 8; i++) xm[k][i] = 16'((i + 1) << 12);
      rm[k] = r;
   endtask

   task automatic check_sweep(input int k, input int n, input int budget);
      logic [15:0] e;
      for (int i = 0; i < n; i++) begin
         wait_sig(k, 0, budget, $sformatf("inst%0d x_valid timeout slot %0d", k, i));
         e = step(xm[k][i], rm[k]);
         chk($sformatf("inst%0d x_idx slot %0d", k, i), 64'(x_idx[k]), 64'(i));
         chk($sformatf("inst%0d x_val slot %0d", k, i), 64'(x_val[k]), 64'(e));
         xm[k][i] = e;
         if (i == 0) begin
            t_first = cyc;
            x_first = x_val[k];
         end
         t_last = cyc;
      end
   endtask

   initial begin
      rst_n   = '0;
      en      = '0;
      mul_ack = '1;
      for (int k = 0; k < NI; k++) lat[k] = 1;
      repeat (3) @(posedge clk);
      #1;

      // T1 reset values
      chk("rst mul_req", 64'(mul_req[0]), 64'd0);
      chk("rst x_valid", 64'(x_valid[0]), 64'd0);
      chk("rst busy",    64'(busy[0]),    64'd0);
      chk("rst overrun", 64'(overrun[0]), 64'd0);
      chk("rst r_val",   64'(r_val[0]),   64'h30000);
      chk("rst mul_a",   64'(mul_a[0]),   64'd0);
      chk("rst x_val",   64'(x_val[0]),   64'd0);
      chk("rst r_val floor inst", 64'(r_val[1]), 64'd0);
      chk("rst r_val wrap inst",  64'(r_val[2]), 64'h3FFFE);
      rst_n = '1;
      en[0] = 1'b1;
      reset_model(0, 18'h30000);
      reset_model(1, 18'h0);
      reset_model(2, 18'h3FFFE);

      // T2 ideal multiplier, first sweep
      wait_sig(0, 1, 40, "T2 req1 timeout");
      chk("T2 req1 mul_a", 64'(mul_a[0]), 64'h1000);
      chk("T2 req1 mul_b", 64'(mul_b[0]), 64'hF000);
      wait_sig(0, 1, 10, "T2 req2 timeout");
      chk("T2 req2 mul_a", 64'(mul_a[0]), 64'h30000);
      chk("T2 req2 mul_b", 64'(mul_b[0]), 64'h0F00);
      check_sweep(0, 8, 10);
      chk("T2 slot0 x_val", 64'(x_first), 64'h2D00);
      chk("T2 sweep span", 64'(t_last - t_first), 64'd35);
      wait_sig(0, 2, 10, "T2 idle timeout");
      chk("T2 r_val after sweep", 64'(r_val[0]), 64'h30002);
      rm[0] = 18'h30002;

      // T3 ack withheld in REQ1
      mul_ack[0] = 1'b0;
      wait_sig(0, 1, 40, "T3 req timeout");
      for (int c = 0; c < 5; c++) begin
         chk("T3 held mul_req", 64'(mul_req[0]), 64'd1);
         chk("T3 held mul_a",   64'(mul_a[0]),   64'(xm[0][0]));
         chk("T3 held mul_b",   64'(mul_b[0]),   64'(18'h10000 - 18'(xm[0][0])));
         @(posedge clk); #1;
      end
      mul_ack[0] = 1'b1;
      check_sweep(0, 8, 20);
      wait_sig(0, 2, 10, "T3 idle timeout");
      chk("T3 r_val after sweep", 64'(r_val[0]), 64'h30004);

      // T4 reset clears overrun, then slow multiplier overruns the epoch
      rst_n[0] = 1'b0;
      @(posedge clk); #1;
      chk("T4 rst overrun", 64'(overrun[0]), 64'd0);
      chk("T4 rst r_val",   64'(r_val[0]),   64'h30000);
      rst_n[0] = 1'b1;
      lat[0]   = 10;
      reset_model(0, 18'h30000);
      check_sweep(0, 8, 80);
      wait_sig(0, 2, 20, "T4 idle timeout");
      chk("T4 overrun sticky", 64'(overrun[0]), 64'd1);
      chk("T4 r_val after sweep", 64'(r_val[0]), 64'h30002);

      // T5 r = 0: every result floors to one LSB
      en[1] = 1'b1;
      check_sweep(1, 8, 40);
      chk("T5 floor x_val", 64'(x_val[1]), 64'd1);
      wait_sig(1, 2, 10, "T5 idle timeout");
      chk("T5 r_val", 64'(r_val[1]), 64'd0);

      // T6 r wraps to its initial value, then async reset mid-sweep
      en[2] = 1'b1;
      check_sweep(2, 8, 40);
      wait_sig(2, 2, 10, "T6 idle timeout");
      chk("T6 r_val wrapped", 64'(r_val[2]), 64'h3FFFE);
      check_sweep(2, 3, 40);
      wait_sig(2, 1, 10, "T6 req timeout");
      rst_n[2] = 1'b0;
      #1;
      chk("T6 async mul_req", 64'(mul_req[2]), 64'd0);
      chk("T6 async busy",    64'(busy[2]),    64'd0);
      chk("T6 async x_val",   64'(x_val[2]),   64'd0);
      chk("T6 async x_idx",   64'(x_idx[2]),   64'd0);
      chk("T6 async r_val",   64'(r_val[2]),   64'h3FFFE);
      @(posedge clk); #1;
      rst_n[2] = 1'b1;
      reset_model(2, 18'h3FFFE);
      check_sweep(2, 1, 40);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not complete");
      $fatal(1);
   end
endmodule
